// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
//   Shared types and constants for the RX block-sync path.
//   - Sync header encodings (data / cmd); the other two codes are invalid.
//   - sync_state_t : block-lock state machine states.
//   - Block / payload / span / gearbox buffer widths.
//   - header_ok()  : true for the two legal sync headers.
// ----------------------------------------------------------------------------
package rx_pkg;

    localparam int unsigned c_PAYLOAD_W  = 64;
    localparam int unsigned c_BLOCK_W    = 66;
    // Stage-1 span: a 66b block starting at any offset 0..65.
    localparam int unsigned c_SPAN_W     = 131;
    localparam int unsigned c_BUF_W      = 194;
    localparam int unsigned c_MAX_OFFSET = 65;

    localparam logic [1:0] c_DATA_HEADER = 2'b01;
    localparam logic [1:0] c_CMD_HEADER  = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    function automatic logic header_ok(input logic [1:0] hdr);
        return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
    endfunction

endpackage

// File: rtl/block_extract.sv
// ----------------------------------------------------------------------------
// block_extract
//   Stage 1 of block sync. On each buffer_dv it captures the 131-bit span of
//   the gearbox buffer selected by gbox_cnt together with the header offset k,
//   then presents the 66b block at that offset combinationally in stage 2.
//
// Ports
//   clk_i, rst_ni  : clock, async active-low reset
//   gbox_buffer    : complete gearbox buffer
//   gbox_cnt       : buffer view window index (0..63)
//   buffer_dv      : buffer update strobe
//   block_offset   : seeker-proposed header offset (sampled only in HUNT)
//   hunt           : block sync is currently in HUNT
//   lock_offset    : offset frozen on VERIFY entry
//   header/payload : stage-2 block fields
//   k              : offset used for the stage-2 block
//   v1             : stage-2 block valid strobe
// ----------------------------------------------------------------------------
module block_extract
    import rx_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [c_BUF_W-1:0]     gbox_buffer,
    input  logic [5:0]             gbox_cnt,
    input  logic                   buffer_dv,
    input  logic [6:0]             block_offset,
    input  logic                   hunt,
    input  logic [6:0]             lock_offset,
    output logic [1:0]             header,
    output logic [c_PAYLOAD_W-1:0] payload,
    output logic [6:0]             k,
    output logic                   v1
);

    logic [c_SPAN_W-1:0]  span_d;
    logic [c_SPAN_W-1:0]  span_q;
    logic [6:0]           k_d;
    logic [6:0]           k_q;
    logic [c_BLOCK_W-1:0] blk;

    // span[130:0] = buffer[193-cnt -: 131]; its LSB sits at bit 63-cnt.
    assign span_d = c_SPAN_W'(gbox_buffer >> (6'd63 - gbox_cnt));

    // Outside HUNT the seeker's proposal is ignored and the frozen offset is
    // reused. Out-of-range proposals clamp to the last legal offset.
    always_comb begin
        k_d = hunt ? block_offset : lock_offset;
        if (k_d > 7'(c_MAX_OFFSET)) begin
            k_d = 7'(c_MAX_OFFSET);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            span_q <= '0;
            k_q    <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= buffer_dv;
            if (buffer_dv) begin
                span_q <= span_d;
                k_q    <= k_d;
            end
        end
    end

    // block = span[130-k -: 66]; its LSB sits at bit 65-k (k <= 65).
    assign blk     = c_BLOCK_W'(span_q >> (7'd65 - k_q));
    assign header  = blk[c_BLOCK_W-1 -: 2];
    assign payload = blk[c_PAYLOAD_W-1:0];
    assign k       = k_q;

endmodule

// File: rtl/block_sync.sv
// ----------------------------------------------------------------------------
// block_sync
//   Block lock and 66b block extraction. Each buffer_dv extracts one block at
//   the current offset, validates its sync header and steps the
//   HUNT / VERIFY / LOCKED machine. While LOCKED every block (including ones
//   with bad headers) is forwarded to the decoder with its raw header.
//   buffer_dv at cycle N -> outputs and state update at N+2.
//
// Parameters
//   LOCK_CNT : consecutive good headers needed to lock (<=127)
//   WIN_LEN  : LOCKED monitoring window length in blocks (<=127)
//   BAD_MAX  : bad headers within one window that drop lock (<=127)
//
// Ports
//   clk_i, rst_ni    : clock, async active-low reset
//   gbox_buffer      : complete gearbox buffer
//   gbox_cnt         : buffer view window index
//   buffer_dv        : buffer data valid strobe
//   block_offset     : header offset proposed by the seeker
//   data_o/header_o  : block payload and raw sync header
//   data_valid_o     : data_o/header_o valid strobe
//   locked_o         : state is LOCKED
//   lock_loss_cnt_o  : saturating count of LOCKED -> HUNT transitions
// ----------------------------------------------------------------------------
module block_sync
    import rx_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned WIN_LEN  = 64,
    parameter int unsigned BAD_MAX  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [c_BUF_W-1:0]     gbox_buffer,
    input  logic [5:0]             gbox_cnt,
    input  logic                   buffer_dv,
    input  logic [6:0]             block_offset,
    output logic [c_PAYLOAD_W-1:0] data_o,
    output logic [1:0]             header_o,
    output logic                   data_valid_o,
    output logic                   locked_o,
    output logic [15:0]            lock_loss_cnt_o
);

    sync_state_t            state;
    logic [6:0]             good_cnt;
    logic [6:0]             win_cnt;
    logic [6:0]             bad_cnt;
    logic [6:0]             lock_offset;

    logic [1:0]             hdr;
    logic [c_PAYLOAD_W-1:0] pay;
    logic [6:0]             k;
    logic                   v1;

    logic                   hdr_ok;
    logic [6:0]             good_inc;
    logic [6:0]             win_inc;
    logic [6:0]             bad_inc;

    block_extract u_extract (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .gbox_buffer  (gbox_buffer),
        .gbox_cnt     (gbox_cnt),
        .buffer_dv    (buffer_dv),
        .block_offset (block_offset),
        .hunt         (state == HUNT),
        .lock_offset  (lock_offset),
        .header       (hdr),
        .payload      (pay),
        .k            (k),
        .v1           (v1)
    );

    assign hdr_ok   = header_ok(hdr);
    assign good_inc = good_cnt + 7'd1;
    assign win_inc  = win_cnt + 7'd1;
    assign bad_inc  = bad_cnt + {6'd0, ~hdr_ok};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= HUNT;
            good_cnt        <= '0;
            win_cnt         <= '0;
            bad_cnt         <= '0;
            lock_offset     <= '0;
            data_o          <= '0;
            header_o        <= '0;
            data_valid_o    <= 1'b0;
            locked_o        <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            data_valid_o <= 1'b0;
            if (v1) begin
                // Emission follows the state on stage-2 entry: the block that
                // locks is not forwarded, the block that unlocks is.
                if (state == LOCKED) begin
                    data_valid_o <= 1'b1;
                    data_o       <= pay;
                    header_o     <= hdr;
                end

                unique case (state)
                    HUNT: begin
                        if (hdr_ok) begin
                            state       <= VERIFY;
                            lock_offset <= k;
                            good_cnt    <= 7'd1;
                        end
                    end

                    VERIFY: begin
                        if (!hdr_ok) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end else if (good_inc == 7'(LOCK_CNT)) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            good_cnt <= good_inc;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end

                    LOCKED: begin
                        // Error limit beats window rollover on the same block.
                        if (bad_inc == 7'(BAD_MAX)) begin
                            state    <= HUNT;
                            locked_o <= 1'b0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                            if (lock_loss_cnt_o != 16'hFFFF) begin
                                lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
                            end
                        end else if (win_inc == 7'(WIN_LEN)) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_inc;
                            bad_cnt <= bad_inc;
                        end
                    end

                    default: begin
                        state    <= HUNT;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_sync.sv
module tb_block_sync;
    import rx_pkg::*;

    localparam int LOCK_CNT = 32;
    localparam int WIN_LEN  = 64;
    localparam int BAD_MAX  = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [193:0] gbox_buffer = '0;
    logic [5:0]   gbox_cnt = '0;
    logic         buffer_dv = 1'b0;
    logic [6:0]   block_offset = '0;
    logic [63:0]  data_o;
    logic [1:0]   header_o;
    logic         data_valid_o;
    logic         locked_o;
    logic [15:0]  lock_loss_cnt_o;

    int tests = 0;
    int fails = 0;
    int dv_seen = 0;
    logic [63:0] last_pay = '0;

    block_sync #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .BAD_MAX(BAD_MAX)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .gbox_buffer     (gbox_buffer),
        .gbox_cnt        (gbox_cnt),
        .buffer_dv       (buffer_dv),
        .block_offset    (block_offset),
        .data_o          (data_o),
        .header_o        (header_o),
        .data_valid_o    (data_valid_o),
        .locked_o        (locked_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: block-level view, one extraction per strobe.
    // ms: 0 hunt, 1 verify, 2 locked.
    // ------------------------------------------------------------------
    int          ms = 0, m_good = 0, m_win = 0, m_bad = 0, m_lock_off = 0, m_loss = 0;
    bit          p_v = 0;
    logic [65:0] p_blk = '0;
    int          p_k = 0;
    bit          e_dv = 0;
    logic [63:0] e_data = '0;
    logic [1:0]  e_hdr = '0;
    bit          e_locked = 0;

    // Block at offset k within view cnt: bits [128-cnt-k +: 66] of the buffer.
    function automatic logic [65:0] ref_block(input logic [193:0] b, input int cnt, input int k);
        logic [193:0] t;
        t = b >> (128 - cnt - k);
        return t[65:0];
    endfunction

    task automatic model_reset();
        ms = 0; m_good = 0; m_win = 0; m_bad = 0; m_lock_off = 0; m_loss = 0;
        p_v = 0; p_blk = '0; p_k = 0;
        e_dv = 0; e_data = '0; e_hdr = '0; e_locked = 0;
    endtask

    task automatic model_step();
        bit          cv;
        logic [65:0] cb;
        int          ck;
        logic [1:0]  h;
        bit          ok;
        cv = buffer_dv;
        ck = 0;
        cb = '0;
        if (cv) begin
            if (ms == 0) ck = (int'(block_offset) > 65) ? 65 : int'(block_offset);
            else         ck = m_lock_off;
            cb = ref_block(gbox_buffer, int'(gbox_cnt), ck);
        end
        e_dv = 0;
        if (p_v) begin
            h  = p_blk[65:64];
            ok = (h == 2'b01) || (h == 2'b10);
            if (ms == 2) begin
                e_dv = 1; e_data = p_blk[63:0]; e_hdr = h;
            end
            if (ms == 0) begin
                if (ok) begin ms = 1; m_lock_off = p_k; m_good = 1; end
            end else if (ms == 1) begin
                if (!ok) begin
                    ms = 0; m_good = 0;
                end else begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin ms = 2; m_win = 0; m_bad = 0; end
                end
            end else begin
                m_win++;
                if (!ok) m_bad++;
                if (m_bad == BAD_MAX) begin
                    ms = 0;
                    if (m_loss < 65535) m_loss++;
                end else if (m_win == WIN_LEN) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end
        p_v = cv; p_blk = cb; p_k = ck;
        e_locked = (ms == 2);
    endtask

    // Compare process: every cycle, 1 time unit after the active edge.
    always @(posedge clk_i) begin
        if (!rst_ni) model_reset();
        else         model_step();
        #1;
        if (data_valid_o === 1'b1) dv_seen++;
        check("data_valid", 66'(data_valid_o), 66'(e_dv));
        check("locked", 66'(locked_o), 66'(e_locked));
        check("lock_loss_cnt", 66'(lock_loss_cnt_o), 66'(m_loss));
        check("data_x", 66'($isunknown(data_o)), 66'd0);
        if (e_dv) begin
            check("header", 66'(header_o), 66'(e_hdr));
            check("data", 66'(data_o), 66'(e_data));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    endfunction

    // Drive one strobe with a block {hdr, random payload} placed at offset kpos.
    task automatic send(input logic [1:0] hdr, input int cnt, input int kpos, input int off);
        logic [223:0] r;
        logic [193:0] b;
        logic [63:0]  pay;
        @(negedge clk_i);
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom();
        b   = r[193:0];
        pay = {$urandom(), $urandom()};
        b[128 - cnt - kpos +: 66] = {hdr, pay};
        last_pay     = pay;
        gbox_buffer  = b;
        gbox_cnt     = 6'(cnt);
        block_offset = 7'(off);
        buffer_dv    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            buffer_dv = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        buffer_dv = 1'b0;
        rst_ni    = 1'b0;
        @(negedge clk_i);
        rst_ni    = 1'b1;
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mask;
        int          pos;
        int          ro;
        int          pct;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_data", 66'(data_o), 66'd0);
        check("rst_header", 66'(header_o), 66'd0);
        check("rst_dv", 66'(data_valid_o), 66'd0);
        check("rst_locked", 66'(locked_o), 66'd0);
        check("rst_loss", 66'(lock_loss_cnt_o), 66'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(1);

        // 1. Lock acquisition at offset 5, view 0
        dv_seen = 0;
        for (int i = 0; i < 31; i++) send(good_hdr(), 0, 5, 5);
        idle(3);
        check("t1_not_locked_31", 66'(locked_o), 66'd0);
        send(good_hdr(), 0, 5, 5);
        @(negedge clk_i);
        buffer_dv = 1'b0;
        #1;
        check("t1_locked_at_n1", 66'(locked_o), 66'd0);
        @(posedge clk_i);
        #2;
        check("t1_locked_at_n2", 66'(locked_o), 66'd1);
        for (int i = 0; i < 8; i++) send(good_hdr(), 0, 5, 5);
        idle(3);
        check("t1_dv_count", 66'(dv_seen), 66'd8);
        check("t1_last_data", 66'(data_o), 66'(last_pay));

        // 2. Failed verification then restart
        reset_dut();
        dv_seen = 0;
        for (int i = 0; i < 10; i++) send(good_hdr(), 0, 5, 5);
        send(2'b11, 0, 5, 5);
        idle(3);
        check("t2_unlocked", 66'(locked_o), 66'd0);
        for (int i = 0; i < 31; i++) send(good_hdr(), 0, 5, 5);
        idle(3);
        check("t2_restart_31", 66'(locked_o), 66'd0);
        send(good_hdr(), 0, 5, 5);
        idle(3);
        check("t2_restart_32", 66'(locked_o), 66'd1);
        check("t2_dv_none", 66'(dv_seen), 66'd0);

        // 3. Window error limit: 15 bad in a window, then 16 bad
        mask = '0;
        for (int j = 0; j < 15; j++) begin
            do pos = $urandom_range(0, 63); while (mask[pos]);
            mask[pos] = 1'b1;
        end
        for (int i = 0; i < 64; i++) send(mask[i] ? bad_hdr() : good_hdr(), 0, 5, 5);
        idle(3);
        check("t3_still_locked", 66'(locked_o), 66'd1);
        check("t3_loss0", 66'(lock_loss_cnt_o), 66'd0);
        for (int i = 0; i < 46; i++) send((i % 3 == 0) ? bad_hdr() : good_hdr(), 0, 5, 5);
        idle(3);
        check("t3_lost", 66'(locked_o), 66'd0);
        check("t3_loss1", 66'(lock_loss_cnt_o), 66'd1);

        // 4. Offset freeze: seeker moves to 40, data stays at 5
        reset_dut();
        dv_seen = 0;
        send(good_hdr(), 0, 5, 5);
        idle(2);
        for (int i = 0; i < 40; i++) send(good_hdr(), $urandom_range(0, 63), 5, 40);
        idle(3);
        check("t4_locked", 66'(locked_o), 66'd1);
        check("t4_dv_count", 66'(dv_seen), 66'd9);
        check("t4_last_data", 66'(data_o), 66'(last_pay));

        // 5. Edge indices (offset 100 clamps to 65)
        reset_dut();
        dv_seen = 0;
        for (int i = 0; i < 36; i++) send(good_hdr(), 63, 65, 100);
        idle(3);
        check("t5_hi_locked", 66'(locked_o), 66'd1);
        check("t5_hi_dv", 66'(dv_seen), 66'd4);
        check("t5_hi_data", 66'(data_o), 66'(last_pay));
        reset_dut();
        dv_seen = 0;
        for (int i = 0; i < 36; i++) send(good_hdr(), 0, 0, 0);
        idle(3);
        check("t5_lo_dv", 66'(dv_seen), 66'd4);
        check("t5_lo_data", 66'(data_o), 66'(last_pay));

        // 6. Reset with a block in flight
        reset_dut();
        for (int i = 0; i < 33; i++) send(good_hdr(), 0, 5, 5);
        @(negedge clk_i);
        dv_seen   = 0;
        buffer_dv = 1'b0;
        rst_ni    = 1'b0;
        #1;
        check("t6_rst_data", 66'(data_o), 66'd0);
        check("t6_rst_header", 66'(header_o), 66'd0);
        check("t6_rst_dv", 66'(data_valid_o), 66'd0);
        check("t6_rst_locked", 66'(locked_o), 66'd0);
        check("t6_rst_loss", 66'(lock_loss_cnt_o), 66'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(4);
        check("t6_no_dv", 66'(dv_seen), 66'd0);

        // Randomized traffic: gaps, varying views, stray offsets, error bursts
        reset_dut();
        ro = $urandom_range(0, 65);
        for (int i = 0; i < 900; i++) begin
            pct = (i >= 300 && i < 500) ? 30 : 3;
            if ($urandom_range(0, 99) < 20) idle(1);
            send(($urandom_range(0, 99) < pct) ? bad_hdr() : good_hdr(),
                 $urandom_range(0, 63), ro,
                 ($urandom_range(0, 99) < 5) ? $urandom_range(0, 127) : ro);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
